// File: rtl/aes_pkg.sv
// Shared AES datapath types and constants used by the round pipeline stages.
package aes_pkg;
    localparam int AES_STATE_W = 128;
    localparam int AES_NR_128  = 10;

    typedef logic [3:0]             round_idx_t;
    typedef logic [AES_STATE_W-1:0] aes_state_t;

    typedef struct packed {
        aes_state_t state;
        round_idx_t round;
        logic       last;
    } ark_beat_t;
endpackage

// File: rtl/aes_skid_buffer.sv
// Two-entry skid buffer: a registered output slot plus one spill slot.
// in_ready depends only on the spill slot, so there is no ready path from out_ready.
module aes_skid_buffer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] skid_data;
    logic         skid_valid;
    logic         accept;
    logic         out_free;

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & ~skid_valid;
    assign out_free = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (out_free) begin
            // The spill slot always drains first so beats leave in arrival order.
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_data  <= in_data;
            skid_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/add_round_key_stage.sv
// AES AddRoundKey pipeline stage: XORs each accepted state with the round key
// chosen by an internal round counter, then hands the result to a skid buffer.
module add_round_key_stage
    import aes_pkg::*;
#(
    parameter int NR     = AES_NR_128,
    parameter int DATA_W = AES_STATE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rk_we,
    input  logic [3:0]        rk_addr,
    input  logic [DATA_W-1:0] rk_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_first,
    input  logic [DATA_W-1:0] state_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] state_out,
    output logic [3:0]        out_round,
    output logic              out_last
);
    if (DATA_W != AES_STATE_W) begin : g_bad_width
        $error("add_round_key_stage: DATA_W must be 128");
    end

    localparam round_idx_t LAST_ROUND = round_idx_t'(NR);

    aes_state_t key_file [NR+1];
    round_idx_t round_cnt;
    round_idx_t round_used;
    logic       accept;
    ark_beat_t  in_beat;
    ark_beat_t  out_beat;

    assign accept     = in_valid & in_ready;
    assign round_used = in_first ? '0 : round_cnt;

    // Key is read before this edge's write lands, so a same-cycle rewrite sees the old key.
    always_comb begin
        in_beat       = '0;
        in_beat.state = state_in ^ key_file[round_used];
        in_beat.round = round_used;
        in_beat.last  = (round_used == LAST_ROUND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            round_cnt <= '0;
            for (int i = 0; i <= NR; i++) key_file[i] <= '0;
        end else begin
            if (accept)
                round_cnt <= (round_used == LAST_ROUND) ? '0 : round_used + 4'd1;
            if (rk_we && rk_addr <= LAST_ROUND)
                key_file[rk_addr] <= rk_data;
        end
    end

    aes_skid_buffer #(
        .W($bits(ark_beat_t))
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_beat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_beat)
    );

    assign state_out = out_beat.state;
    assign out_round = out_beat.round;
    assign out_last  = out_beat.last;
endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed bench for add_round_key_stage with hand-computed expectations.
module tb_add_round_key_stage;
    logic         clk = 1'b0;
    logic         rst;
    logic         rk_we;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic [3:0]   out_round;
    logic         out_last;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    add_round_key_stage dut (
        .clk       (clk),
        .rst       (rst),
        .rk_we     (rk_we),
        .rk_addr   (rk_addr),
        .rk_data   (rk_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .out_round (out_round),
        .out_last  (out_last)
    );

    function automatic logic [127:0] kpat(int i);
        logic [7:0] b;
        b = i[7:0];
        return {16{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_key(int idx, logic [127:0] val);
        rk_we   = 1'b1;
        rk_addr = idx[3:0];
        rk_data = val;
        tick();
        rk_we   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rk_we = 1'b0; rk_addr = '0; rk_data = '0;
        in_valid = 1'b0; in_first = 1'b0; state_in = '0; out_ready = 1'b1;
        tick();
        tick();
        vectors++;
        if ({out_valid, in_ready, out_round, out_last} !== {1'b0, 1'b1, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_ctrl got v=%b rdy=%b rnd=%0d last=%b want 0 1 0 0",
                     out_valid, in_ready, out_round, out_last);
        end
        vectors++;
        if (state_out !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_state got %h want 0", state_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        write_key(0, 128'h000102030405060708090a0b0c0d0e0f);
        in_valid = 1'b1; in_first = 1'b1;
        state_in = 128'h00112233445566778899aabbccddeeff;
        tick();
        in_valid = 1'b0; in_first = 1'b0;
        vectors++;
        if (state_out !== 128'h00102030405060708090a0b0c0d0e0f0) begin
            miscompares++;
            $display("FAIL basic_xor got %h want 00102030405060708090a0b0c0d0e0f0", state_out);
        end
        vectors++;
        if ({out_valid, out_round, out_last} !== {1'b1, 4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_ctrl got v=%b rnd=%0d last=%b want 1 0 0",
                     out_valid, out_round, out_last);
        end
        tick();
    endtask

    task automatic test_stream();
        for (int i = 0; i <= 10; i++) write_key(i, kpat(i));
        out_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            in_valid = 1'b1; in_first = (j == 0); state_in = '0;
            tick();
            vectors++;
            if ({out_valid, out_round, out_last} !== {1'b1, 4'(j % 11), (j == 10)}) begin
                miscompares++;
                $display("FAIL stream_ctrl beat %0d got v=%b rnd=%0d last=%b want 1 %0d %b",
                         j, out_valid, out_round, out_last, j % 11, (j == 10));
            end
            vectors++;
            if (state_out !== kpat(j % 11)) begin
                miscompares++;
                $display("FAIL stream_data beat %0d got %h want %h", j, state_out, kpat(j % 11));
            end
        end
        in_valid = 1'b0; in_first = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid = 1'b1; in_first = 1'b1; state_in = 128'h1;
        tick();
        in_first = 1'b0; state_in = 128'h2;
        tick();
        state_in = 128'h3;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ready_low got %b want 0", in_ready);
        end
        tick();
        vectors++;
        if ({out_valid, in_ready, out_round, state_out} !== {1'b1, 1'b0, 4'd0, 128'h1}) begin
            miscompares++;
            $display("FAIL bp_hold got v=%b rdy=%b rnd=%0d %h want 1 0 0 1",
                     out_valid, in_ready, out_round, state_out);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        vectors++;
        if ({out_valid, in_ready, out_round, state_out} !==
            {1'b1, 1'b1, 4'd1, 128'h01010101010101010101010101010103}) begin
            miscompares++;
            $display("FAIL bp_second got v=%b rdy=%b rnd=%0d %h want 1 1 1 0101..03",
                     out_valid, in_ready, out_round, state_out);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_no_dup got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_same_cycle_write();
        write_key(3, 128'd0);
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            in_valid = 1'b1; in_first = (r == 0); state_in = '0;
            if (r == 3) begin
                rk_we = 1'b1; rk_addr = 4'd3; rk_data = '1;
            end
            tick();
            rk_we = 1'b0;
        end
        vectors++;
        if ({out_round, state_out} !== {4'd3, 128'd0}) begin
            miscompares++;
            $display("FAIL wr_old_key got rnd=%0d %h want 3 0", out_round, state_out);
        end
        for (int r = 0; r < 4; r++) begin
            in_valid = 1'b1; in_first = (r == 0); state_in = '0;
            tick();
        end
        vectors++;
        if ({out_round, state_out} !== {4'd3, {128{1'b1}}}) begin
            miscompares++;
            $display("FAIL wr_new_key got rnd=%0d %h want 3 ff..ff", out_round, state_out);
        end
        in_valid = 1'b0; in_first = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_first = 1'b1; state_in = 128'h5;
        tick();
        in_first = 1'b0; state_in = 128'h6;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({out_valid, in_ready, state_out} !== {1'b0, 1'b1, 128'd0}) begin
            miscompares++;
            $display("FAIL rst_mid got v=%b rdy=%b %h want 0 1 0", out_valid, in_ready, state_out);
        end
        out_ready = 1'b1;
        in_valid = 1'b1; in_first = 1'b0; state_in = 128'h77;
        tick();
        in_valid = 1'b0;
        vectors++;
        if ({out_valid, out_round, state_out} !== {1'b1, 4'd0, 128'h77}) begin
            miscompares++;
            $display("FAIL rst_next got v=%b rnd=%0d %h want 1 0 77", out_valid, out_round, state_out);
        end
        tick();
    endtask

    task automatic test_first_mid();
        logic [127:0] k0, k5, exp;
        k0 = {16{8'ha5}};
        k5 = 128'h0123456789abcdef0123456789abcdef;
        write_key(0, k0);
        write_key(5, k5);
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            in_valid = 1'b1; in_first = (j == 0); state_in = '0;
            tick();
        end
        in_first = 1'b1; state_in = 128'h3c;
        tick();
        vectors++;
        if ({out_round, state_out} !== {4'd0, k0 ^ 128'h3c}) begin
            miscompares++;
            $display("FAIL first_mid got rnd=%0d %h want 0 %h", out_round, state_out, k0 ^ 128'h3c);
        end
        in_valid = 1'b0; in_first = 1'b0;
        write_key(11, '1);
        for (int j = 0; j < 11; j++) begin
            in_valid = 1'b1; in_first = (j == 0); state_in = '0;
            tick();
            exp = (j == 0) ? k0 : (j == 5) ? k5 : 128'd0;
            vectors++;
            if ({out_round, state_out} !== {4'(j), exp}) begin
                miscompares++;
                $display("FAIL oob_write round %0d got rnd=%0d %h want %h",
                         j, out_round, state_out, exp);
            end
        end
        in_valid = 1'b0; in_first = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stream();
        test_back_to_back();
        test_same_cycle_write();
        test_reset_mid();
        test_first_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
